// File: rtl/hs_stream_fifo.sv
// First-word-fall-through valid/ready stream FIFO with occupancy count,
// almost-full flag and synchronous flush. Handshake outputs depend only on registered state.
module hs_stream_fifo #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 4,
  parameter int AFULL_TH = 3,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  count,
  output logic              almost_full
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Full/empty come from the count so pointer equality is never ambiguous.
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // rst gates s_ready so the producer sees back-pressure while held in reset.
  assign s_ready     = rst & ~w_full;
  assign m_valid     = ~w_empty;
  assign m_data      = r_mem[r_rd_ptr];
  assign count       = r_count;
  assign almost_full = (r_count >= CNT_W'(AFULL_TH));

  assign w_push = s_valid & s_ready;
  assign w_pop  = m_valid & m_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      // Flush wins over any handshake on the same edge; the presented word is dropped.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= s_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_hs_stream_fifo.sv
// Directed and randomised checks of hs_stream_fifo (DEPTH=4, AFULL_TH=3)
// against hand-computed values and a queue reference model.
module tb_hs_stream_fifo;

  localparam int DATA_W   = 16;
  localparam int DEPTH    = 4;
  localparam int AFULL_TH = 3;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;
  logic [2:0]        count;
  logic              almost_full;

  int vectors = 0;
  int errs    = 0;

  hs_stream_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .count(count), .almost_full(almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] exp_seq[4];
  int sent, recv, cyc;
  logic pred_push, pred_pop;

  initial begin
    rst = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    tick(); tick();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_count", count, 0);
    chk("rst_afull", almost_full, 0);
    rst = 1'b1;
    #1 chk("release_s_ready", s_ready, 1);

    // Three pushes with the consumer stalled
    tick();
    s_valid = 1'b1; s_data = 16'h0011; tick();
    chk("t1_first_fwft", m_data, 16'h0011);
    chk("t1_first_valid", m_valid, 1);
    s_data = 16'h0022; tick();
    chk("t1_count2", count, 2);
    chk("t1_afull_below", almost_full, 0);
    s_data = 16'h0033; tick();
    s_valid = 1'b0;
    chk("t1_count3", count, 3);
    chk("t1_afull_at_th", almost_full, 1);
    chk("t1_head", m_data, 16'h0011);
    tick();
    chk("t1_head_stable", m_data, 16'h0011);
    exp_seq = '{16'h0011, 16'h0022, 16'h0033, 16'h0000};
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t1_drain_order", m_data, exp_seq[i]);
      tick();
    end
    m_ready = 1'b0;
    chk("t1_empty_count", count, 0);
    chk("t1_empty_valid", m_valid, 0);

    // Full: pop does not open a push slot on the same edge
    s_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      s_data = 16'(16'h0100 + i); tick();
    end
    chk("t2_full_count", count, 4);
    chk("t2_full_s_ready", s_ready, 0);
    s_data = 16'h00AA; m_ready = 1'b1; tick();
    chk("t2_pop_no_push", count, 3);
    chk("t2_head_after_pop", m_data, 16'h0102);
    m_ready = 1'b0;
    chk("t2_s_ready_reopen", s_ready, 1);
    tick();
    s_valid = 1'b0;
    chk("t2_refill_count", count, 4);
    exp_seq = '{16'h0102, 16'h0103, 16'h0104, 16'h00AA};
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_drain_order", m_data, exp_seq[i]);
      tick();
    end
    m_ready = 1'b0;
    chk("t2_empty", count, 0);

    // Streaming: one word per cycle, wraps pointers several times
    s_valid = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_data = 16'(i); tick();
      chk("t3_stream_data", m_data, 32'(i));
      chk("t3_stream_count", count, 1);
    end
    s_valid = 1'b0; tick();
    m_ready = 1'b0;
    chk("t3_tail_count", count, 0);
    chk("t3_tail_valid", m_valid, 0);

    // Random handshake against a queue model
    sent = 0; recv = 0; cyc = 0; q.delete();
    while (recv < 1000 && cyc < 20000) begin
      if (!s_valid && sent < 1000 && $urandom_range(1) == 1) begin
        s_valid = 1'b1; s_data = 16'(sent * 7 + 3);
      end
      m_ready = ($urandom_range(1) == 1);
      chk("t4_count", count, q.size());
      chk("t4_m_valid", m_valid, (q.size() != 0));
      chk("t4_s_ready", s_ready, (q.size() != DEPTH));
      if (q.size() != 0) chk("t4_m_data", m_data, q[0]);
      pred_push = s_valid && (q.size() < DEPTH);
      pred_pop  = m_ready && (q.size() != 0);
      tick();
      cyc++;
      if (pred_pop) begin
        void'(q.pop_front());
        recv++;
      end
      if (pred_push) begin
        q.push_back(s_data);
        sent++;
        s_valid = 1'b0;
      end
    end
    chk("t4_all_received", recv, 1000);
    s_valid = 1'b0; m_ready = 1'b0;
    #1 chk("t4_final_count", count, 0);

    // Flush drops the stored words and the word presented with it
    s_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      s_data = 16'(16'h0C00 + i); tick();
    end
    flush = 1'b1; s_data = 16'h0BAD; tick();
    flush = 1'b0; s_valid = 1'b0;
    chk("t5_flush_count", count, 0);
    chk("t5_flush_valid", m_valid, 0);
    chk("t5_flush_s_ready", s_ready, 1);
    chk("t5_flush_afull", almost_full, 0);
    s_valid = 1'b1; s_data = 16'h0D01; tick();
    s_valid = 1'b0;
    chk("t5_post_flush_data", m_data, 16'h0D01);
    chk("t5_post_flush_count", count, 1);
    m_ready = 1'b1; tick();
    m_ready = 1'b0;
    chk("t5_post_flush_empty", count, 0);

    // Asynchronous reset between edges with words stored
    s_valid = 1'b1;
    s_data = 16'h0E01; tick();
    s_data = 16'h0E02; tick();
    s_data = 16'h0E03; tick();
    s_valid = 1'b0;
    chk("t6_pre_count", count, 3);
    #3 rst = 1'b0;
    #1;
    chk("t6_async_valid", m_valid, 0);
    chk("t6_async_count", count, 0);
    chk("t6_async_afull", almost_full, 0);
    chk("t6_async_s_ready", s_ready, 0);
    tick();
    rst = 1'b1;
    #1 chk("t6_release_s_ready", s_ready, 1);
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_stale_valid", m_valid, 0);
      chk("t6_no_stale_data", m_data, 0);
    end
    m_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
